// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// op encodings, FSM state encodings and iteration counter sizing.
package muldiv_sequencer_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_ITER = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // Iteration counter needs to reach WIDTH-1 with one spare bit of headroom.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

  function automatic logic op_is_div(input op_t o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input op_t o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Issue/result bus between the EX stage and the mult/div sequencer.
// MULDIV_HILO_WRITE_EN adds the MTHI/MTLO write signals.
interface muldiv_sequencer_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
`ifdef MULDIV_HILO_WRITE_EN
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] hilo_wdata;

  modport master (output start, op, rs_val, rt_val, hi_we, lo_we, hilo_wdata,
                  input  busy, done, div_zero, hi, lo);
  modport slave  (input  start, op, rs_val, rt_val, hi_we, lo_we, hilo_wdata,
                  output busy, done, div_zero, hi, lo);
`else
  modport master (output start, op, rs_val, rt_val,
                  input  busy, done, div_zero, hi, lo);
  modport slave  (input  start, op, rs_val, rt_val,
                  output busy, done, div_zero, hi, lo);
`endif
endinterface

// File: rtl/muldiv_sequencer_step.sv
// Combinational single iteration of the shift-add multiply or
// restoring divide. acc carries one extra bit for the add carry / trial sign.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] sr,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH:0]   acc_next,
  output logic [WIDTH-1:0] sr_next
);

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;

  // One multiply or divide step selected by is_div.
  always_comb begin
    acc_next = acc;
    sr_next  = sr;
    mul_sum  = sr[0] ? (acc + {1'b0, operand}) : acc;
    shifted  = {acc[WIDTH-1:0], sr[WIDTH-1]};
    diff     = {1'b0, shifted} - {2'b00, operand};
    if (!is_div) begin
      acc_next = {1'b0, mul_sum[WIDTH:1]};
      sr_next  = {mul_sum[0], sr[WIDTH-1:1]};
    end else if (!diff[WIDTH+1]) begin
      acc_next = diff[WIDTH:0];
      sr_next  = {sr[WIDTH-2:0], 1'b1};
    end else begin
      acc_next = shifted;
      sr_next  = {sr[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer with HI/LO registers.
// Optional MTHI/MTLO write path under MULDIV_HILO_WRITE_EN.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic                clock,
  input logic                reset,
  muldiv_sequencer_if.slave  bus
);

  localparam int CW = cnt_width(WIDTH);

  state_t             state, state_next;
  op_t                op_q;
  logic [WIDTH-1:0]   rs_q, rt_q, md, sr, hi_q, lo_q;
  logic [WIDTH:0]     acc, acc_next;
  logic [WIDTH-1:0]   sr_next;
  logic [CW-1:0]      cnt;
  logic               neg_p, neg_r, dz;
  logic               rs_neg, rt_neg;
  logic [WIDTH-1:0]   rs_abs, rt_abs;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   res_hi, res_lo;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (op_is_div(op_q)),
    .acc      (acc),
    .sr       (sr),
    .operand  (md),
    .acc_next (acc_next),
    .sr_next  (sr_next)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state and status outputs.
  always_comb begin
    state_next   = state;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    bus.div_zero = 1'b0;
    case (state)
      S_IDLE: if (bus.start) state_next = S_PREP;
      S_PREP: begin
        bus.busy   = 1'b1;
        state_next = S_ITER;
      end
      S_ITER: begin
        bus.busy = 1'b1;
        if (cnt == CW'(WIDTH - 1)) state_next = S_FIX;
      end
      S_FIX: begin
        bus.busy   = 1'b1;
        state_next = S_DONE;
      end
      S_DONE: begin
        bus.done     = 1'b1;
        bus.div_zero = dz;
        state_next   = bus.start ? S_PREP : S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Operand magnitudes and sign-corrected final results.
  always_comb begin
    rs_neg = op_is_signed(op_q) && rs_q[WIDTH-1];
    rt_neg = op_is_signed(op_q) && rt_q[WIDTH-1];
    rs_abs = rs_neg ? -rs_q : rs_q;
    rt_abs = rt_neg ? -rt_q : rt_q;
    prod   = {acc[WIDTH-1:0], sr};
    res_hi = '0;
    res_lo = '0;
    if (!op_is_div(op_q)) begin
      if (neg_p) prod = -prod;
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end else if (dz) begin
      // Divide-by-zero result is defined on the raw operand, not the magnitude.
      res_hi = rs_q;
      res_lo = '1;
    end else begin
      res_hi = neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      res_lo = neg_p ? -sr : sr;
    end
  end

  // Operand capture, iteration datapath and HI/LO update.
  always_ff @(posedge clock) begin
    if (reset) begin
      op_q  <= OP_MULT;
      rs_q  <= '0;
      rt_q  <= '0;
      md    <= '0;
      sr    <= '0;
      acc   <= '0;
      cnt   <= '0;
      neg_p <= 1'b0;
      neg_r <= 1'b0;
      dz    <= 1'b0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            op_q <= op_t'(bus.op);
            rs_q <= bus.rs_val;
            rt_q <= bus.rt_val;
          end
`ifdef MULDIV_HILO_WRITE_EN
          if (bus.hi_we) hi_q <= bus.hilo_wdata;
          if (bus.lo_we) lo_q <= bus.hilo_wdata;
`endif
        end
        S_PREP: begin
          acc   <= '0;
          cnt   <= '0;
          neg_p <= rs_neg ^ rt_neg;
          neg_r <= rs_neg;
          dz    <= op_is_div(op_q) && (rt_q == '0);
          if (op_is_div(op_q)) begin
            md <= rt_abs;
            sr <= rs_abs;
          end else begin
            md <= rs_abs;
            sr <= rt_abs;
          end
        end
        S_ITER: begin
          acc <= acc_next;
          sr  <= sr_next;
          cnt <= cnt + 1'b1;
        end
        S_FIX: begin
          hi_q <= res_hi;
          lo_q <= res_lo;
        end
        default: ;
      endcase
    end
  end

  assign bus.hi = hi_q;
  assign bus.lo = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer with hand-computed expectations.
module tb_muldiv_sequencer;

  localparam logic [1:0] MULT  = 2'b00;
  localparam logic [1:0] MULTU = 2'b01;
  localparam logic [1:0] DIV   = 2'b10;
  localparam logic [1:0] DIVU  = 2'b11;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  muldiv_sequencer_if #(.WIDTH(32)) bus();

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  // Starts an op at the current negedge, scrambles inputs after capture,
  // and returns the cycle (start cycle = 0) at which done is seen.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int cyc, output logic busy1);
    bus.start = 1'b1; bus.op = o; bus.rs_val = a; bus.rt_val = b;
    @(negedge clock);
    bus.start = 1'b0; bus.op = ~o; bus.rs_val = 32'h1234_5678; bus.rt_val = 32'h0;
    busy1 = bus.busy;
    cyc = 1;
    while (!bus.done && cyc < 100) begin
      @(negedge clock);
      cyc++;
    end
  endtask

  task automatic test_reset();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.div_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: busy=%b done=%b dz=%b, required 0 0 0", bus.busy, bus.done, bus.div_zero);
    end
    checks++;
    if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
      errors++;
      $display("FAIL reset_hilo: hi=%h lo=%h, required 0 0", bus.hi, bus.lo);
    end
  endtask

  task automatic test_multu();
    int cyc; logic b1;
    run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, b1);
    checks++;
    if (b1 !== 1'b1) begin errors++; $display("FAIL multu_busy: busy=%b, required 1", b1); end
    checks++;
    if (cyc !== 35) begin errors++; $display("FAIL multu_latency: done at %0d, required 35", cyc); end
    checks++;
    if (bus.hi !== 32'hFFFF_FFFE || bus.lo !== 32'h0000_0001 || bus.div_zero !== 1'b0) begin
      errors++;
      $display("FAIL multu_result: hi=%h lo=%h dz=%b, required fffffffe 00000001 0", bus.hi, bus.lo, bus.div_zero);
    end
    @(negedge clock);
    checks++;
    if (bus.done !== 1'b0 || bus.hi !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL done_pulse: done=%b hi=%h, required 0 fffffffe", bus.done, bus.hi);
    end
  endtask

  task automatic test_mult();
    int cyc; logic b1;
    run_op(MULT, 32'hFFFF_FFF9, 32'd3, cyc, b1);
    checks++;
    if (cyc !== 35 || bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFEB) begin
      errors++;
      $display("FAIL mult_neg7x3: cyc=%0d hi=%h lo=%h, required 35 ffffffff ffffffeb", cyc, bus.hi, bus.lo);
    end
    @(negedge clock);
    run_op(MULT, 32'd5, 32'hFFFF_FFFC, cyc, b1);
    checks++;
    if (cyc !== 35 || bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFEC) begin
      errors++;
      $display("FAIL mult_5xneg4: cyc=%0d hi=%h lo=%h, required 35 ffffffff ffffffec", cyc, bus.hi, bus.lo);
    end
    @(negedge clock);
  endtask

  task automatic test_div();
    int cyc; logic b1;
    run_op(DIV, 32'hFFFF_FFF9, 32'd2, cyc, b1);
    checks++;
    if (cyc !== 35 || bus.lo !== 32'hFFFF_FFFD || bus.hi !== 32'hFFFF_FFFF || bus.div_zero !== 1'b0) begin
      errors++;
      $display("FAIL div_neg7by2: cyc=%0d hi=%h lo=%h dz=%b, required 35 ffffffff fffffffd 0", cyc, bus.hi, bus.lo, bus.div_zero);
    end
    @(negedge clock);
    run_op(DIV, 32'd7, 32'hFFFF_FFFE, cyc, b1);
    checks++;
    if (bus.lo !== 32'hFFFF_FFFD || bus.hi !== 32'h0000_0001) begin
      errors++;
      $display("FAIL div_7byneg2: hi=%h lo=%h, required 00000001 fffffffd", bus.hi, bus.lo);
    end
    @(negedge clock);
    run_op(DIVU, 32'd100, 32'd7, cyc, b1);
    checks++;
    if (bus.lo !== 32'd14 || bus.hi !== 32'd2) begin
      errors++;
      $display("FAIL divu_100by7: hi=%h lo=%h, required 00000002 0000000e", bus.hi, bus.lo);
    end
    @(negedge clock);
    run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, cyc, b1);
    checks++;
    if (bus.lo !== 32'h8000_0000 || bus.hi !== 32'h0 || bus.div_zero !== 1'b0) begin
      errors++;
      $display("FAIL div_min_by_neg1: hi=%h lo=%h dz=%b, required 0 80000000 0", bus.hi, bus.lo, bus.div_zero);
    end
    @(negedge clock);
  endtask

  task automatic test_div_zero();
    int cyc; logic b1;
    run_op(DIVU, 32'd100, 32'd0, cyc, b1);
    checks++;
    if (cyc !== 35 || bus.div_zero !== 1'b1 || bus.hi !== 32'd100 || bus.lo !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL divu_zero: cyc=%0d dz=%b hi=%h lo=%h, required 35 1 00000064 ffffffff", cyc, bus.div_zero, bus.hi, bus.lo);
    end
    @(negedge clock);
    checks++;
    if (bus.div_zero !== 1'b0) begin errors++; $display("FAIL dz_pulse: dz=%b, required 0", bus.div_zero); end
    run_op(DIV, 32'hFFFF_FFFB, 32'd0, cyc, b1);
    checks++;
    if (bus.div_zero !== 1'b1 || bus.hi !== 32'hFFFF_FFFB || bus.lo !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL div_zero_neg: dz=%b hi=%h lo=%h, required 1 fffffffb ffffffff", bus.div_zero, bus.hi, bus.lo);
    end
    @(negedge clock);
  endtask

  task automatic test_start_while_busy();
    int cyc;
    bus.start = 1'b1; bus.op = MULTU; bus.rs_val = 32'd6; bus.rt_val = 32'd7;
    @(negedge clock);
    bus.start = 1'b0;
    cyc = 1;
    while (!bus.done && cyc < 100) begin
      if (cyc == 10) begin
        bus.start = 1'b1; bus.op = DIVU; bus.rs_val = 32'd99; bus.rt_val = 32'd0;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clock);
      cyc++;
    end
    bus.start = 1'b0;
    checks++;
    if (cyc !== 35 || bus.hi !== 32'h0 || bus.lo !== 32'd42 || bus.div_zero !== 1'b0) begin
      errors++;
      $display("FAIL start_mid_iter: cyc=%0d hi=%h lo=%h dz=%b, required 35 0 0000002a 0", cyc, bus.hi, bus.lo, bus.div_zero);
    end
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    int cyc; logic b1;
    run_op(MULTU, 32'd3, 32'd5, cyc, b1);
    checks++;
    if (cyc !== 35 || bus.lo !== 32'd15) begin
      errors++;
      $display("FAIL b2b_first: cyc=%0d lo=%h, required 35 0000000f", cyc, bus.lo);
    end
    run_op(DIVU, 32'd50, 32'd8, cyc, b1);
    checks++;
    if (cyc !== 35 || b1 !== 1'b1 || bus.lo !== 32'd6 || bus.hi !== 32'd2) begin
      errors++;
      $display("FAIL b2b_second: cyc=%0d busy=%b hi=%h lo=%h, required 35 1 00000002 00000006", cyc, b1, bus.hi, bus.lo);
    end
    @(negedge clock);
  endtask

  task automatic test_reset_mid_op();
    int cyc;
    int seen_done;
    bus.start = 1'b1; bus.op = MULTU; bus.rs_val = 32'd9; bus.rt_val = 32'd9;
    @(negedge clock);
    bus.start = 1'b0;
    for (cyc = 1; cyc < 11; cyc++) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_iter: busy=%b done=%b hi=%h lo=%h, required 0 0 0 0", bus.busy, bus.done, bus.hi, bus.lo);
    end
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (bus.done === 1'b1) seen_done++;
    end
    checks++;
    if (seen_done !== 0) begin
      errors++;
      $display("FAIL reset_no_done: done pulses=%0d, required 0", seen_done);
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.op = 2'b00; bus.rs_val = '0; bus.rt_val = '0;
`ifdef MULDIV_HILO_WRITE_EN
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.hilo_wdata = '0;
`endif
    repeat (3) @(negedge clock);
    test_reset();
    reset = 1'b0;
    @(negedge clock);
    test_multu();
    test_mult();
    test_div();
    test_div_zero();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
